boot_loader_ctrl: RTL and testbench

BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

---
 rtl/boot_loader_ctrl_if.sv | 40 ++++
 rtl/boot_loader_ctrl.sv | 165 ++++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_ctrl_if.sv
// Bus bundle between the boot loader controller and its surroundings:
// loader byte stream, core memory port and shared memory port.
interface boot_loader_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic [15:0]           word_count_i;
    logic                  run_i;
    logic                  byte_valid_i;
    logic [7:0]            byte_data_i;
    logic                  byte_ready_o;
    logic [DATA_WIDTH-1:0] core_Address_i;
    logic [DATA_WIDTH-1:0] core_WriteData_i;
    logic                  core_MemWrite_i;
    logic [DATA_WIDTH-1:0] core_ReadData_o;
    logic [DATA_WIDTH-1:0] mem_Address_o;
    logic [DATA_WIDTH-1:0] mem_WriteData_o;
    logic                  mem_MemWrite_o;
    logic [DATA_WIDTH-1:0] mem_ReadData_i;
    logic                  core_reset_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  error_o;

    // controller side
    modport slave (
        input  start_i, word_count_i, run_i, byte_valid_i, byte_data_i,
               core_Address_i, core_WriteData_i, core_MemWrite_i, mem_ReadData_i,
        output byte_ready_o, core_ReadData_o, mem_Address_o, mem_WriteData_o,
               mem_MemWrite_o, core_reset_o, busy_o, done_o, error_o
    );

    // environment side (loader, core and memory)
    modport master (
        output start_i, word_count_i, run_i, byte_valid_i, byte_data_i,
               core_Address_i, core_WriteData_i, core_MemWrite_i, mem_ReadData_i,
        input  byte_ready_o, core_ReadData_o, mem_Address_o, mem_WriteData_o,
               mem_MemWrite_o, core_reset_o, busy_o, done_o, error_o
    );
endinterface

// File: rtl/boot_loader_ctrl.sv
// Boot loader controller: assembles a little-endian byte stream into words,
// writes them to the shared memory while the core is held in reset, then
// hands the memory port over to the core.
//
// state | meaning
// IDLE  | core held in reset, waiting for start or run
// RECV  | collecting the four bytes of the current word
// WRITE | one-cycle write of the assembled word
// DONE  | one-cycle load-complete pulse
// RUN   | core released, memory port mirrors the core
module boot_loader_ctrl #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    boot_loader_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, RUN} state_t;

    localparam logic [16:0] DEPTH_MAX = 17'(MEMORY_DEPTH);

    state_t                state_q, state_d;
    logic [15:0]           count_q;
    logic [15:0]           word_idx_q;
    logic [1:0]            byte_idx_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  error_q;

    logic                  count_ok;
    logic                  start_window;
    logic                  start_ok;
    logic                  start_bad;
    logic                  byte_take;
    logic                  last_word;
    logic [DATA_WIDTH-1:0] word_addr;

    logic                  byte_ready;
    logic                  busy;
    logic                  done;
    logic                  core_rst;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign count_ok     = (bus.word_count_i != 16'd0) && ({1'b0, bus.word_count_i} <= DEPTH_MAX);
    assign start_window = (state_q == IDLE) || (state_q == RUN);
    assign start_ok     = start_window && bus.start_i && count_ok;
    assign start_bad    = start_window && bus.start_i && !count_ok;
    assign byte_take    = (state_q == RECV) && bus.byte_valid_i;
    assign last_word    = (word_idx_q == (count_q - 16'd1));
    assign word_addr    = BASE_ADDR + (DATA_WIDTH'(word_idx_q) << 2);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; reset forces the quiet output set
    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        core_rst   = 1'b1;
        mem_we     = 1'b0;
        mem_addr   = addr_q;
        mem_wdata  = data_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    if (count_ok) state_d = RECV;
                end else if (bus.run_i) begin
                    state_d = RUN;
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (bus.byte_valid_i && (byte_idx_q == 2'd3)) state_d = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = word_addr;
                mem_wdata = word_q;
                state_d   = last_word ? DONE : RECV;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                core_rst  = 1'b0;
                mem_we    = bus.core_MemWrite_i;
                mem_addr  = bus.core_Address_i;
                mem_wdata = bus.core_WriteData_i;
                if (bus.start_i && count_ok) state_d = RECV;
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            state_d    = IDLE;
            byte_ready = 1'b0;
            busy       = 1'b0;
            done       = 1'b0;
            core_rst   = 1'b1;
            mem_we     = 1'b0;
            mem_addr   = '0;
            mem_wdata  = '0;
        end
    end

    // Load bookkeeping: count/index latching, byte assembly, held loader values, sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            error_q    <= 1'b0;
        end else begin
            if (start_ok) begin
                count_q    <= bus.word_count_i;
                word_idx_q <= '0;
                byte_idx_q <= '0;
                error_q    <= 1'b0;
            end else if (start_bad) begin
                error_q    <= 1'b1;
            end
            if (byte_take) begin
                word_q[{byte_idx_q, 3'b000} +: 8] <= bus.byte_data_i;
                byte_idx_q <= byte_idx_q + 2'd1;
            end
            if (state_q == WRITE) begin
                addr_q     <= word_addr;
                data_q     <= word_q;
                byte_idx_q <= '0;
                if (!last_word) word_idx_q <= word_idx_q + 16'd1;
            end
        end
    end

    assign bus.byte_ready_o    = byte_ready;
    assign bus.busy_o          = busy;
    assign bus.done_o          = done;
    assign bus.error_o         = error_q;
    assign bus.core_reset_o    = core_rst;
    assign bus.mem_MemWrite_o  = mem_we;
    assign bus.mem_Address_o   = mem_addr;
    assign bus.mem_WriteData_o = mem_wdata;
    assign bus.core_ReadData_o = bus.mem_ReadData_i;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Bench for boot_loader_ctrl: directed scenarios plus randomized loads,
// checked against a word/address model built from the byte stream.
module tb_boot_loader_ctrl;

    localparam int          DW    = 32;
    localparam int          DEPTH = 32;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    boot_loader_ctrl_if #(.DATA_WIDTH(DW)) bus();

    boot_loader_ctrl #(
        .DATA_WIDTH  (DW),
        .MEMORY_DEPTH(DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  stim_q[$];
    logic [63:0] obs_q[$];

    // Record every loader write (core held in reset) as {address, data}
    always @(negedge clk) begin
        if (!reset && bus.mem_MemWrite_o === 1'b1 && bus.core_reset_o === 1'b1)
            obs_q.push_back({bus.mem_Address_o, bus.mem_WriteData_o});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        check("rst_core_reset", 64'(bus.core_reset_o), 64'd1);
        check("rst_ready",      64'(bus.byte_ready_o), 64'd0);
        check("rst_busy",       64'(bus.busy_o), 64'd0);
        check("rst_done",       64'(bus.done_o), 64'd0);
        check("rst_error",      64'(bus.error_o), 64'd0);
        check("rst_we",         64'(bus.mem_MemWrite_o), 64'd0);
        check("rst_addr",       64'(bus.mem_Address_o), 64'd0);
        check("rst_wdata",      64'(bus.mem_WriteData_o), 64'd0);
        check("rst_rdata_pass", 64'(bus.core_ReadData_o), 64'(bus.mem_ReadData_i));
        reset = 1'b0;
        tick;
        check("idle_core_reset", 64'(bus.core_reset_o), 64'd1);
        check("idle_busy",       64'(bus.busy_o), 64'd0);
    endtask

    task automatic fill_random(input int n);
        stim_q.delete();
        repeat (4 * n) stim_q.push_back(8'($urandom));
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
        int budget;
        repeat (gap) begin
            bus.byte_valid_i = 1'b0;
            bus.byte_data_i  = 8'($urandom);
            tick;
        end
        bus.byte_valid_i = 1'b1;
        bus.byte_data_i  = b;
        budget = 0;
        while (bus.byte_ready_o !== 1'b1 && budget < 20) begin
            tick;
            budget++;
        end
        check("byte_ready_wait", 64'(bus.byte_ready_o), 64'd1);
        if (noise) begin
            bus.start_i      = 1'($urandom);
            bus.word_count_i = 16'd1;
            bus.run_i        = 1'($urandom);
        end
        tick;
        bus.byte_valid_i = 1'b0;
        bus.start_i      = 1'b0;
        bus.run_i        = 1'b0;
    endtask

    // Load stim_q as n words; expected writes come from the byte list alone
    task automatic load(input int n, input int gap, input bit noise);
        logic [63:0] exp_q[$];
        logic [63:0] last;
        int          waited;
        for (int i = 0; i < n; i++)
            exp_q.push_back({BASE + 32'(4 * i),
                             stim_q[4*i+3], stim_q[4*i+2], stim_q[4*i+1], stim_q[4*i]});
        last = exp_q[n-1];
        obs_q.delete();
        bus.start_i      = 1'b1;
        bus.word_count_i = 16'(n);
        tick;
        bus.start_i = 1'b0;
        check("load_busy",       64'(bus.busy_o), 64'd1);
        check("load_core_reset", 64'(bus.core_reset_o), 64'd1);
        check("load_error_clr",  64'(bus.error_o), 64'd0);
        foreach (stim_q[k])
            send_byte(stim_q[k], (gap < 0) ? int'($urandom_range(0, 3)) : gap, noise);
        waited = 0;
        while (bus.done_o !== 1'b1 && waited < 10) begin
            tick;
            waited++;
        end
        check("done_pulse",      64'(bus.done_o), 64'd1);
        check("done_core_reset", 64'(bus.core_reset_o), 64'd1);
        check("held_addr",       64'(bus.mem_Address_o), 64'(last[63:32]));
        check("held_wdata",      64'(bus.mem_WriteData_o), 64'(last[31:0]));
        tick;
        check("run_core_reset",  64'(bus.core_reset_o), 64'd0);
        check("done_one_cycle",  64'(bus.done_o), 64'd0);
        check("run_busy",        64'(bus.busy_o), 64'd0);
        check("write_count",     64'(obs_q.size()), 64'(n));
        for (int i = 0; i < n && i < obs_q.size(); i++)
            check($sformatf("write_%0d", i), obs_q[i], exp_q[i]);
    endtask

    initial begin
        bus.start_i          = 1'b0;
        bus.word_count_i     = '0;
        bus.run_i            = 1'b0;
        bus.byte_valid_i     = 1'b0;
        bus.byte_data_i      = '0;
        bus.core_Address_i   = '0;
        bus.core_WriteData_i = '0;
        bus.core_MemWrite_i  = 1'b0;
        bus.mem_ReadData_i   = 32'hA5A5_5A5A;

        do_reset;

        // two words back-to-back, then the same with 3-cycle gaps
        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        load(2, 0, 1'b0);
        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        load(2, 3, 1'b0);

        // RUN: zero-latency mirror of the core port
        bus.core_Address_i   = 32'h10;
        bus.core_WriteData_i = $urandom;
        bus.core_MemWrite_i  = 1'b1;
        bus.mem_ReadData_i   = $urandom;
        #1;
        check("mirror_addr",  64'(bus.mem_Address_o), 64'(32'h10));
        check("mirror_wdata", 64'(bus.mem_WriteData_o), 64'(bus.core_WriteData_i));
        check("mirror_we",    64'(bus.mem_MemWrite_o), 64'd1);
        check("mirror_rdata", 64'(bus.core_ReadData_o), 64'(bus.mem_ReadData_i));
        bus.core_MemWrite_i = 1'b0;

        // bad count in RUN keeps the core running
        bus.start_i      = 1'b1;
        bus.word_count_i = 16'd0;
        tick;
        bus.start_i = 1'b0;
        check("run_bad_core_reset", 64'(bus.core_reset_o), 64'd0);
        check("run_bad_busy",       64'(bus.busy_o), 64'd0);
        check("run_bad_error",      64'(bus.error_o), 64'd1);

        // reload of one word from RUN
        fill_random(1);
        load(1, -1, 1'b0);

        // bad counts in IDLE: zero, then DEPTH+1 (with run_i also high)
        do_reset;
        bus.start_i      = 1'b1;
        bus.word_count_i = 16'd0;
        tick;
        check("idle_zero_busy",  64'(bus.busy_o), 64'd0);
        check("idle_zero_ready", 64'(bus.byte_ready_o), 64'd0);
        check("idle_zero_error", 64'(bus.error_o), 64'd1);
        bus.word_count_i = 16'(DEPTH + 1);
        bus.run_i        = 1'b1;
        tick;
        bus.start_i = 1'b0;
        bus.run_i   = 1'b0;
        check("idle_over_busy",       64'(bus.busy_o), 64'd0);
        check("idle_over_core_reset", 64'(bus.core_reset_o), 64'd1);
        check("idle_over_error",      64'(bus.error_o), 64'd1);
        tick;
        check("error_sticky",         64'(bus.error_o), 64'd1);
        fill_random(3);
        load(3, -1, 1'b0);

        // reset after two bytes of word 1: word 0 stays written, no other write
        do_reset;
        fill_random(2);
        obs_q.delete();
        bus.start_i      = 1'b1;
        bus.word_count_i = 16'd2;
        tick;
        bus.start_i = 1'b0;
        for (int k = 0; k < 6; k++) send_byte(stim_q[k], 0, 1'b0);
        reset = 1'b1;
        tick;
        check("abort_core_reset", 64'(bus.core_reset_o), 64'd1);
        check("abort_busy",       64'(bus.busy_o), 64'd0);
        check("abort_ready",      64'(bus.byte_ready_o), 64'd0);
        reset = 1'b0;
        tick;
        tick;
        check("abort_idle_busy",   64'(bus.busy_o), 64'd0);
        check("abort_write_count", 64'(obs_q.size()), 64'd1);
        if (obs_q.size() > 0)
            check("abort_word0", obs_q[0], {BASE, stim_q[3], stim_q[2], stim_q[1], stim_q[0]});
        fill_random(2);
        load(2, 0, 1'b0);

        // run_i in IDLE releases the core without touching memory
        do_reset;
        obs_q.delete();
        bus.run_i = 1'b1;
        tick;
        bus.run_i = 1'b0;
        check("runi_core_reset", 64'(bus.core_reset_o), 64'd0);
        check("runi_busy",       64'(bus.busy_o), 64'd0);
        tick;
        check("runi_no_write",   64'(obs_q.size()), 64'd0);

        // randomized reloads with gaps, ignored start/run noise and a busy core port
        for (int r = 0; r < 8; r++) begin
            int n;
            n = (r == 7) ? DEPTH : int'($urandom_range(1, 6));
            bus.core_Address_i   = $urandom;
            bus.core_WriteData_i = $urandom;
            bus.core_MemWrite_i  = 1'b1;
            fill_random(n);
            load(n, -1, 1'b1);
        end
        bus.core_MemWrite_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
